// File: rtl/dsc_dot_seq.sv
// dsc_dot_seq
// Dot-product sequencer and accumulator built around one external dsc_mul.
// Each accepted 4-bit operand pair is handled in three steps. The multiplier
// is cleared, run until it raises its completion flag, and its product is
// added into a saturating accumulator. After the pair marked last, the sum,
// the total multiplier run cycles and a sticky error flag are offered on an
// output valid/ready stream.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   in_valid/in_ready      operand stream handshake
//   in_a, in_b, in_last    unsigned operands and end-of-vector marker
//   mul_rst, mul_en        control of the attached dsc_mul
//   mul_a, mul_b           operands presented to dsc_mul
//   mul_z, mul_ov          product and completion flag from dsc_mul
//   out_valid/out_ready    result stream handshake
//   out_sum                accumulated sum (saturates to all-ones)
//   out_cycles             summed RUN cycles (saturates at 16'hFFFF)
//   out_err                timeout or accumulator saturation in this vector
module dsc_dot_seq #(
   parameter int ACC_W   = 12,
   parameter int TIMEOUT = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   input  logic             in_last,
   output logic             mul_rst,
   output logic             mul_en,
   output logic [3:0]       mul_a,
   output logic [3:0]       mul_b,
   input  logic [7:0]       mul_z,
   input  logic             mul_ov,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [15:0]      out_cycles,
   output logic             out_err
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      CAPTURE,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [3:0]       a_q;
   logic [3:0]       b_q;
   logic             last_q;
   logic [7:0]       z_q;
   logic             good_q;
   logic             err_q;
   logic [ACC_W-1:0] acc_q;
   logic [15:0]      cyc_q;
   logic [CNT_W-1:0] run_cnt;
   logic [ACC_W:0]   sum_ext;
   logic             run_timeout;

   // One extra adder bit exposes overflow, which turns into saturation.
   assign sum_ext     = {1'b0, acc_q} + (ACC_W + 1)'(z_q);
   assign run_timeout = (run_cnt == RUN_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and outputs. The multiplier reset and the input ready
   // are also gated by rst directly, so the multiplier is cleared in the same
   // cycle as this block and no pair can be accepted during reset.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      mul_rst    = rst;
      mul_en     = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            mul_rst    = 1'b1;
            state_next = RUN;
         end
         RUN: begin
            mul_en = 1'b1;
            if (mul_ov || run_timeout) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            state_next = last_q ? DONE : IDLE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign mul_a      = a_q;
   assign mul_b      = b_q;
   assign out_sum    = acc_q;
   assign out_cycles = cyc_q;
   assign out_err    = err_q;

   // Datapath. The operands are latched on acceptance and held through CLEAR
   // and RUN. In RUN, a completion flag takes priority over a timeout on the
   // same cycle. A timed-out product is never added but still marks the
   // vector as erroneous.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         last_q  <= 1'b0;
         z_q     <= '0;
         good_q  <= 1'b0;
         err_q   <= 1'b0;
         acc_q   <= '0;
         cyc_q   <= '0;
         run_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q    <= in_a;
                  b_q    <= in_b;
                  last_q <= in_last;
               end
            end
            CLEAR: begin
               run_cnt <= '0;
            end
            RUN: begin
               run_cnt <= run_cnt + 1'b1;
               if (cyc_q != 16'hFFFF) begin
                  cyc_q <= cyc_q + 16'd1;
               end
               if (mul_ov) begin
                  z_q    <= mul_z;
                  good_q <= 1'b1;
               end else if (run_timeout) begin
                  good_q <= 1'b0;
                  err_q  <= 1'b1;
               end
            end
            CAPTURE: begin
               if (good_q) begin
                  if (sum_ext[ACC_W]) begin
                     acc_q <= '1;
                     err_q <= 1'b1;
                  end else begin
                     acc_q <= sum_ext[ACC_W-1:0];
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  acc_q <= '0;
                  cyc_q <= '0;
                  err_q <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
